cache_mem_arbiter: RTL and testbench

- Shares one 256-bit cacheline memory port between the instruction cache and the data cache downward-facing ports.
- Sits between the two caches' dfp interfaces and the cacheline adapter / memory model.
- Each requester holds its request level until it sees a resp pulse. The arbiter latches one request, drives it downstream from registers, and routes the response back to that requester only.
- Arbitration is round-robin; it can be compiled to fixed data-cache priority instead.

---
 rtl/cache_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Shares one cacheline memory port between the icache and dcache.
//             Latches one request, drives it downstream from registers and
//             routes the response strobe back to the owning requester.
//  Options  : ARB_RR_EN - defined: round-robin on contention;
//                         undefined: dcache always wins on contention.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   // icache downward-facing port
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   // dcache downward-facing port
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   // shared memory port
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic c_OWN_I = 1'b0;
   localparam logic c_OWN_D = 1'b1;

   state_t              state_q;
   logic                owner_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_read_q;
   logic                mem_write_q;
   logic [LINE_W-1:0]   mem_wdata_q;

   logic                w_i_req;
   logic                w_d_req;
   logic                w_grant_d;

   assign w_i_req = i_read;
   assign w_d_req = d_read | d_write;

`ifdef ARB_RR_EN
   logic rr_last_q;

   // On contention the requester that did not win last time gets the grant.
   assign w_grant_d = w_d_req & (~w_i_req | (rr_last_q == c_OWN_I));

   // Remember the most recent winner; reset to I so D wins the first contest.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last_q <= c_OWN_I;
      end else if (state_q == IDLE && (w_i_req || w_d_req)) begin
         rr_last_q <= w_grant_d;
      end
   end
`else
   // Fixed priority: any pending dcache request beats the icache.
   assign w_grant_d = w_d_req;
`endif

   // Grant/complete FSM; all downstream outputs come straight from registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= c_OWN_D;
         mem_addr_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_i_req || w_d_req) begin
                  state_q <= BUSY;
                  owner_q <= w_grant_d;
                  if (w_grant_d) begin
                     // A writeback takes precedence over a simultaneous read;
                     // the dcache re-issues the read after its response.
                     mem_addr_q  <= d_addr;
                     mem_write_q <= d_write;
                     mem_read_q  <= d_read & ~d_write;
                     mem_wdata_q <= d_wdata;
                  end else begin
                     mem_addr_q  <= i_addr;
                     mem_write_q <= 1'b0;
                     mem_read_q  <= 1'b1;
                     mem_wdata_q <= '0;
                  end
               end
            end
            BUSY: begin
               // Requester inputs are ignored until memory answers.
               if (mem_resp) begin
                  state_q     <= IDLE;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_wdata = mem_wdata_q;

   // Read data is broadcast; only the response strobe picks the destination.
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;
   assign i_resp  = mem_resp & (state_q == BUSY) & (owner_q == c_OWN_I);
   assign d_resp  = mem_resp & (state_q == BUSY) & (owner_q == c_OWN_D);

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_mem_arbiter
//  Purpose  : Self-checking bench for cache_mem_arbiter: directed scenarios
//             followed by random requester/memory traffic, compared against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] i_addr;
   logic              i_read;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic [ADDR_W-1:0] d_addr;
   logic              d_read;
   logic              d_write;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic              mem_write;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;

   int errors = 0;
   int checks = 0;

   // Reference model: one outstanding transaction record plus arbitration history.
   bit                m_busy;
   bit                m_owner_d;
   bit                m_last_d;
   logic [ADDR_W-1:0] e_addr;
   logic              e_read;
   logic              e_write;
   logic [LINE_W-1:0] e_wdata;
   bit                e_wvalid;
   bit                saw_i;
   bit                saw_d;

   cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_addr    (i_addr),
      .i_read    (i_read),
      .i_rdata   (i_rdata),
      .i_resp    (i_resp),
      .d_addr    (d_addr),
      .d_read    (d_read),
      .d_write   (d_write),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_resp    (d_resp),
      .mem_addr  (mem_addr),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] v;
      for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_owner_d = 1; m_last_d = 0;
      e_addr = '0; e_read = 0; e_write = 0; e_wdata = '0; e_wvalid = 1;
   endtask

   // Apply the arbitration rules to whatever the requesters present at this edge.
   task automatic model_edge();
      bit win_d;
      if (rst) begin
         model_reset();
      end else if (!m_busy) begin
         if (i_read || d_read || d_write) begin
            win_d = d_read || d_write;
`ifdef ARB_RR_EN
            if (i_read && win_d) win_d = !m_last_d;
`endif
            m_busy = 1; m_owner_d = win_d; m_last_d = win_d;
            if (win_d) begin
               e_addr = d_addr; e_write = d_write; e_read = d_read && !d_write;
               e_wdata = d_wdata; e_wvalid = 1;
            end else begin
               e_addr = i_addr; e_read = 1; e_write = 0; e_wvalid = 0;
            end
         end
      end else if (mem_resp) begin
         m_busy = 0; e_read = 0; e_write = 0;
      end
   endtask

   // One cycle: inputs already driven at posedge+1; check mid-cycle, then clock.
   task automatic tick();
      #3;
      saw_i = i_resp;
      saw_d = d_resp;
      chk("mem_addr",  {{(LINE_W-ADDR_W){1'b0}}, mem_addr}, {{(LINE_W-ADDR_W){1'b0}}, e_addr});
      chk("mem_read",  {{(LINE_W-1){1'b0}}, mem_read},  {{(LINE_W-1){1'b0}}, e_read});
      chk("mem_write", {{(LINE_W-1){1'b0}}, mem_write}, {{(LINE_W-1){1'b0}}, e_write});
      if (e_wvalid) chk("mem_wdata", mem_wdata, e_wdata);
      chk("i_resp", {{(LINE_W-1){1'b0}}, i_resp}, {{(LINE_W-1){1'b0}}, (mem_resp && m_busy && !m_owner_d)});
      chk("d_resp", {{(LINE_W-1){1'b0}}, d_resp}, {{(LINE_W-1){1'b0}}, (mem_resp && m_busy && m_owner_d)});
      chk("i_rdata", i_rdata, mem_rdata);
      chk("d_rdata", d_rdata, mem_rdata);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
   endtask

   initial begin
      rst = 1; idle_inputs();
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      @(posedge clk); #1;
      model_reset();

      // Reset values, with a stray mem_resp present during reset
      mem_resp = 1; tick();
      mem_resp = 0; tick();
      rst = 0;

      // Icache only: grant latency 1, response after 4 busy cycles
      i_read = 1; i_addr = 32'h0000_1000; tick();
      chk("ic_grant_read", {{(LINE_W-1){1'b0}}, mem_read}, {{(LINE_W-1){1'b0}}, 1'b1});
      chk("ic_grant_addr", {{(LINE_W-ADDR_W){1'b0}}, mem_addr}, 256'h1000);
      repeat (3) tick();
      tick();
      mem_resp = 1; mem_rdata = {32{8'hAA}}; tick();
      chk("ic_saw_i_resp", {{(LINE_W-1){1'b0}}, saw_i}, {{(LINE_W-1){1'b0}}, 1'b1});
      i_read = 0; mem_resp = 0; tick();
      chk("ic_read_clear", {{(LINE_W-1){1'b0}}, mem_read}, '0);

      // Contention: D first, then I (round-robin) or D again (fixed priority)
      i_read = 1; i_addr = 32'h100; d_read = 1; d_addr = 32'h200; tick();
      chk("cont_first_D", {{(LINE_W-ADDR_W){1'b0}}, mem_addr}, 256'h200);
      repeat (2) tick();
      mem_resp = 1; mem_rdata = rand_line(); tick();
      mem_resp = 0; tick();
`ifdef ARB_RR_EN
      chk("cont_second", {{(LINE_W-ADDR_W){1'b0}}, mem_addr}, 256'h100);
`else
      chk("cont_second", {{(LINE_W-ADDR_W){1'b0}}, mem_addr}, 256'h200);
`endif
      tick();
      mem_resp = 1; tick();
      idle_inputs(); tick();
      mem_resp = 1; tick();
      mem_resp = 0; tick();

      // Dirty miss: write+read together -> write wins; address change ignored
      d_write = 1; d_read = 1; d_addr = 32'h400; d_wdata = {32{8'h55}}; tick();
      d_addr = 32'h600;
      repeat (3) tick();
      chk("dm_addr_held", {{(LINE_W-ADDR_W){1'b0}}, mem_addr}, 256'h400);
      mem_resp = 1; tick();
      mem_resp = 0; d_write = 0; d_addr = 32'h800; i_read = 1; i_addr = 32'h900; tick();
`ifdef ARB_RR_EN
      chk("dm_refill_order", {{(LINE_W-ADDR_W){1'b0}}, mem_addr}, 256'h900);
`else
      chk("dm_refill_order", {{(LINE_W-ADDR_W){1'b0}}, mem_addr}, 256'h800);
`endif
      tick();
      mem_resp = 1; tick();
      mem_resp = 0; tick();
      mem_resp = 1; tick();
      idle_inputs(); tick();

      // Stray response while idle
      mem_resp = 1; tick();
      mem_resp = 0; tick();

      // Reset during BUSY drops the transaction; contention then goes to D
      d_read = 1; d_addr = 32'h300; tick();
      rst = 1; tick();
      rst = 0; d_read = 0; mem_resp = 1; tick();
      mem_resp = 0; i_read = 1; i_addr = 32'h700; d_read = 1; d_addr = 32'hA00; tick();
      chk("post_rst_D", {{(LINE_W-ADDR_W){1'b0}}, mem_addr}, 256'hA00);
      mem_resp = 1; tick();
      idle_inputs(); tick();

      // Random traffic: caches hold requests until their response strobe
      for (int n = 0; n < 3000; n++) begin
         mem_resp  = ($urandom % 3) == 0;
         mem_rdata = rand_line();
         tick();
         if (!i_read || saw_i) begin
            i_read = $urandom % 2;
            i_addr = $urandom & 32'hFFFF_FFE0;
         end
         if (!(d_read || d_write) || saw_d) begin
            int r;
            r = $urandom % 4;
            d_read  = (r == 1) || (r == 3);
            d_write = (r >= 2);
            d_addr  = $urandom & 32'hFFFF_FFE0;
            d_wdata = rand_line();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
